spi_master_arbiter: RTL and testbench
=====================================

// Module: spi_master_arbiter
// PURPOSE
//  Shares one transmitter_SPI master among N_REQ requesters and sequences each transfer.
//  - Picks a requester round-robin and routes its byte and mode (CKP/CPH) to the master.
//  - Pulses-and-holds strt, tracks CS (active low) for start/end of frame, reports done/err per grant.
//  - Sits between the system requesters and transmitter_SPI, on the same clock domain.
// PARAMETERS
//  N_REQ    4     number of requesters (>=2)
//  DW       8     data width per transfer (matches transmitter data_in)
//  TIMEOUT  1023  max cycles waiting on each CS edge before abort; counter width $clog2(TIMEOUT+1)
// PORTS
//  clk        in   1         system clock, all logic on rising edge
//  rst        in   1         reset, asynchronous, active-high
//  req        in   N_REQ     request level per requester
//  req_data   in   N_REQ*DW  byte per requester, requester i at [i*DW +: DW]
//  req_mode   in   N_REQ*2   {CKP,CPH} per requester, requester i at [i*2 +: 2]
//  gnt        out  N_REQ     one-hot grant, held for whole transfer
//  done       out  1         1-cycle pulse, transfer of granted requester finished
//  err        out  1         1-cycle pulse coincident with done when transfer aborted by timeout
//  strt       out  1         start request to transmitter_SPI
//  data_in    out  DW        byte to transmitter_SPI
//  CKP        out  1         clock polarity to transmitter_SPI
//  CPH        out  1         clock phase to transmitter_SPI
//  CS         in   1         chip select from transmitter_SPI, low while frame active
// BEHAVIOUR
//  Reset (async, immediate):
//   - gnt=0, done=0, err=0, strt=0, data_in=0, CKP=0, CPH=0
//   - state=IDLE, rr pointer=N_REQ-1 (requester 0 highest), timeout counter=0
//  All outputs registered. FSM states and transitions:
//   - IDLE: if |req, winner = first set req scanning from ptr+1 upward, modulo N_REQ.
//     Register gnt=onehot(winner), data_in/CKP/CPH from winner's slice, ptr=winner; ->LAUNCH.
//     Grant is visible 1 cycle after req is sampled.
//   - LAUNCH: strt=1, cnt=0; ->WAIT_LO.
//   - WAIT_LO: hold strt=1 until CS sampled 0, then strt=0, cnt=0; ->WAIT_HI.
//     If cnt reaches TIMEOUT first: strt=0, abort.
//   - WAIT_HI: wait CS sampled 1; then done=1 for 1 cycle, gnt cleared same edge; ->GAP.
//     If cnt reaches TIMEOUT first: abort.
//   - Abort: done=1 and err=1 for 1 cycle, gnt and strt cleared; ->GAP.
//   - GAP: one idle cycle, CS guaranteed high to the slave between frames; ->IDLE.
//  data_in/CKP/CPH stay stable from LAUNCH through the done cycle. They keep their last value while IDLE.
//  Changes to req/req_data/req_mode after the grant are ignored until the next IDLE.
//  Dropping req mid-transfer does not cancel; the transfer completes and done still pulses.
//  Back-to-back: a requester holding req keeps it through done and rearbitrates in IDLE.
//   - Others then win first (ptr advanced).
//   - Min period per transfer = frame length + 4 cycles.
//  CS low in IDLE/GAP/LAUNCH: ignored (not this block's frame).
//  CS staying high through LAUNCH is normal; only its falling edge in WAIT_LO counts.
//  Counter saturates at TIMEOUT; it does not wrap.
// TESTING
//  1. Reset mid-WAIT_HI -> next edge sees strt=0, gnt=0, done=0. After release, req=4'b0001 grants gnt=0001.
//  2. req=0001, data 8'hA5, mode 2'b10 -> gnt=0001, data_in=A5, CKP=1, CPH=0, strt high until CS low.
//     Then done pulse 1 cycle after CS high, err=0.
//  3. req=1111 held, four frames -> grant order 0001,0010,0100,1000,0001. Each done pulses once.
//  4. req=0101 with ptr=0 -> gnt=0100 first, then 0001. MOSI bytes match the granted requester's data.
//  5. Force CS high (model stall), TIMEOUT=15 -> strt drops 16 cycles after LAUNCH, done=err=1 pulse, GAP then IDLE.
//  6. Requester drops req and changes req_data during WAIT_HI -> frame unchanged, done still pulses, no regrant.

Source files
------------

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter that shares one transmitter_SPI master among N_REQ requesters.
// Latches the winner's byte and mode, drives strt and follows CS to detect the end of the frame or a timeout.
module spi_master_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*DW-1:0] req_data,
    input  logic [N_REQ*2-1:0] req_mode,
    output logic [N_REQ-1:0]   gnt,
    output logic               done,
    output logic               err,
    output logic               strt,
    output logic [DW-1:0]      data_in,
    output logic               CKP,
    output logic               CPH,
    input  logic               CS
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_LO, WAIT_HI, GAP} state_t;

    state_t            state_reg, state_next;
    logic [N_REQ-1:0]  gnt_reg, gnt_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;
    logic              strt_reg, strt_next;
    logic [DW-1:0]     data_reg, data_next;
    logic              ckp_reg, ckp_next;
    logic              cph_reg, cph_next;
    logic [PW-1:0]     ptr_reg, ptr_next;
    logic [CW-1:0]     cnt_reg, cnt_next;

    logic [DW-1:0]     data_arr [N_REQ];
    logic [1:0]        mode_arr [N_REQ];
    logic [PW-1:0]     win_idx;
    logic              timed_out;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign data_arr[gi] = req_data[gi*DW +: DW];
            assign mode_arr[gi] = req_mode[gi*2 +: 2];
        end
    endgenerate

    // Lowest requester above ptr wins; if none, wrap to the lowest requester overall.
    always_comb begin
        win_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) win_idx = PW'(i);
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i] && (PW'(i) > ptr_reg)) win_idx = PW'(i);
        end
    end

    assign timed_out = (cnt_reg == CW'(TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            gnt_reg   <= '0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            strt_reg  <= 1'b0;
            data_reg  <= '0;
            ckp_reg   <= 1'b0;
            cph_reg   <= 1'b0;
            ptr_reg   <= PW'(N_REQ - 1);
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
            strt_reg  <= strt_next;
            data_reg  <= data_next;
            ckp_reg   <= ckp_next;
            cph_reg   <= cph_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (|req) state_next = LAUNCH;
            LAUNCH:  state_next = WAIT_LO;
            WAIT_LO: if (!CS) state_next = WAIT_HI;
                     else if (timed_out) state_next = GAP;
            WAIT_HI: if (CS || timed_out) state_next = GAP;
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        gnt_next  = gnt_reg;
        done_next = 1'b0;
        err_next  = 1'b0;
        strt_next = strt_reg;
        data_next = data_reg;
        ckp_next  = ckp_reg;
        cph_next  = cph_reg;
        ptr_next  = ptr_reg;
        cnt_next  = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    gnt_next  = N_REQ'(1) << win_idx;
                    data_next = data_arr[win_idx];
                    ckp_next  = mode_arr[win_idx][1];
                    cph_next  = mode_arr[win_idx][0];
                    ptr_next  = win_idx;
                end
            end
            LAUNCH: begin
                strt_next = 1'b1;
                cnt_next  = '0;
            end
            WAIT_LO: begin
                if (!CS) begin
                    strt_next = 1'b0;
                    cnt_next  = '0;
                end else if (timed_out) begin
                    strt_next = 1'b0;
                    gnt_next  = '0;
                    done_next = 1'b1;
                    err_next  = 1'b1;
                end else begin
                    cnt_next  = cnt_reg + 1'b1;
                end
            end
            WAIT_HI: begin
                if (CS) begin
                    gnt_next  = '0;
                    done_next = 1'b1;
                end else if (timed_out) begin
                    strt_next = 1'b0;
                    gnt_next  = '0;
                    done_next = 1'b1;
                    err_next  = 1'b1;
                end else begin
                    cnt_next  = cnt_reg + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign gnt     = gnt_reg;
    assign done    = done_reg;
    assign err     = err_reg;
    assign strt    = strt_reg;
    assign data_in = data_reg;
    assign CKP     = ckp_reg;
    assign CPH     = cph_reg;
endmodule

// File: tb/tb_spi_master_arbiter.sv
// Self-checking bench for spi_master_arbiter: directed scenarios plus randomized frames,
// checked against a round-robin reference model and a simple CS-driving slave.
module tb_spi_master_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 15;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N*2-1:0]  req_mode;
    logic [N-1:0]    gnt;
    logic            done, err, strt, CKP, CPH, CS;
    logic [DW-1:0]   data_in;

    int checks = 0;
    int errors = 0;
    int ptr_m  = N - 1;

    spi_master_arbiter #(.N_REQ(N), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_mode(req_mode),
        .gnt(gnt), .done(done), .err(err), .strt(strt), .data_in(data_in),
        .CKP(CKP), .CPH(CPH), .CS(CS)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Requester whose circular distance after the last winner is smallest.
    function automatic int pick(input logic [N-1:0] r);
        int best = -1;
        int bd = 2 * N;
        for (int i = 0; i < N; i++) begin
            int d = (i - ptr_m - 1 + 2 * N) % N;
            if (r[i] && d < bd) begin
                bd = d;
                best = i;
            end
        end
        return best;
    endfunction

    // Entered just after a negedge with the DUT idle; returns just after a negedge with the DUT idle.
    task automatic frame(input logic [N-1:0] r, input logic [N*DW-1:0] dv, input logic [N*2-1:0] mv,
                         input int d_lo, input int len, input bit keep, input bit mutate);
        int w;
        logic [DW-1:0] ed;
        logic [1:0] em;
        req = r; req_data = dv; req_mode = mv;
        w = pick(r);
        ed = dv[w*DW +: DW];
        em = mv[w*2 +: 2];
        ptr_m = w;
        @(negedge clk);
        chk("gnt", 32'(gnt), 32'(1 << w));
        chk("data_in", 32'(data_in), 32'(ed));
        chk("ckp", 32'(CKP), 32'(em[1]));
        chk("cph", 32'(CPH), 32'(em[0]));
        chk("strt_launch", 32'(strt), 0);
        if (mutate) begin
            req = N'($urandom); req_data = {$urandom, $urandom}; req_mode = N*2'($urandom);
        end
        @(negedge clk);
        chk("strt_hi", 32'(strt), 1);
        repeat (d_lo) begin
            @(negedge clk);
            chk("strt_hold", 32'(strt), 1);
        end
        CS = 1'b0;
        @(negedge clk);
        chk("strt_lo", 32'(strt), 0);
        chk("gnt_hold", 32'(gnt), 32'(1 << w));
        repeat (len - 1) begin
            @(negedge clk);
            chk("done_early", 32'(done), 0);
        end
        if (mutate) begin
            req = '0; req_data = {$urandom, $urandom};
        end
        CS = 1'b1;
        @(negedge clk);
        chk("done", 32'(done), 1);
        chk("err", 32'(err), 0);
        chk("gnt_clr", 32'(gnt), 0);
        chk("data_stable", 32'(data_in), 32'(ed));
        chk("mode_stable", 32'({CKP, CPH}), 32'(em));
        if (!keep) req = '0;
        @(negedge clk);
        chk("done_pulse", 32'(done), 0);
        chk("err_idle", 32'(err), 0);
        $display("frame req=%b gnt=%0d data=%h mode=%b lo_delay=%0d len=%0d", r, w, ed, em, d_lo, len);
    endtask

    initial begin
        int w, cnt;
        rst = 1'b1; CS = 1'b1; req = '0; req_data = '0; req_mode = '0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_strt", 32'(strt), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_data", 32'({data_in, CKP, CPH}), 0);
        rst = 1'b0;
        @(negedge clk);

        // Single requester with a fixed byte and mode
        frame(4'b0001, {24'h0, 8'hA5}, 8'b0000_0010, 2, 3, 0, 0);

        // Reset while the frame is in WAIT_HI
        req = 4'b0010; req_data = {$urandom, $urandom};
        repeat (2) @(negedge clk);
        CS = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_strt", 32'(strt), 0);
        chk("arst_gnt", 32'(gnt), 0);
        chk("arst_done", 32'(done), 0);
        @(negedge clk);
        rst = 1'b0; CS = 1'b1; req = '0; ptr_m = N - 1;
        @(negedge clk);
        frame(4'b0001, {$urandom, $urandom}, 8'($urandom), 1, 2, 0, 0);

        // Pointer at 0: requester 2 beats requester 0, then requester 0
        frame(4'b0101, {$urandom, $urandom}, 8'($urandom), 0, 4, 0, 0);
        frame(4'b0101, {$urandom, $urandom}, 8'($urandom), 3, 1, 0, 0);

        // Move the pointer to 3, then all requesters held back-to-back
        frame(4'b1000, {$urandom, $urandom}, 8'($urandom), 0, 2, 0, 0);
        for (int k = 0; k < 5; k++) begin
            w = pick(4'b1111);
            chk("rr_order", 32'(w), 32'(k % N));
            frame(4'b1111, {$urandom, $urandom}, 8'($urandom), k % 3, 2 + k, 1, 0);
        end
        req = '0;

        // Requester drops req and changes data mid-frame: no cancel, no regrant
        frame(4'b0100, {$urandom, $urandom}, 8'($urandom), 1, 5, 0, 1);
        repeat (2) @(negedge clk);
        chk("no_regrant", 32'(gnt), 0);

        // CS never falls: abort out of WAIT_LO after TIMEOUT+1 cycles of strt
        req = 4'b0010; req_data = {$urandom, $urandom};
        w = pick(req); ptr_m = w;
        @(negedge clk);
        chk("to_gnt", 32'(gnt), 32'(1 << w));
        req = '0;
        @(negedge clk);
        cnt = 0;
        while (strt === 1'b1 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        chk("to_lo_len", 32'(cnt), TO + 1);
        chk("to_lo_done", 32'(done), 1);
        chk("to_lo_err", 32'(err), 1);
        chk("to_lo_gnt", 32'(gnt), 0);
        @(negedge clk);
        chk("to_lo_pulse", 32'({done, err}), 0);
        $display("timeout waiting for CS low, strt cycles=%0d", cnt);

        // CS never rises: abort out of WAIT_HI
        req = 4'b1001; req_data = {$urandom, $urandom};
        w = pick(req); ptr_m = w;
        @(negedge clk);
        chk("to2_gnt", 32'(gnt), 32'(1 << w));
        req = '0;
        @(negedge clk);
        CS = 1'b0;
        @(negedge clk);
        chk("to2_strt", 32'(strt), 0);
        cnt = 0;
        while (done !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        chk("to_hi_len", 32'(cnt), TO + 1);
        chk("to_hi_err", 32'(err), 1);
        chk("to_hi_gnt", 32'(gnt), 0);
        CS = 1'b1;
        @(negedge clk);
        chk("to_hi_pulse", 32'({done, err}), 0);
        $display("timeout waiting for CS high, cycles=%0d", cnt);

        // Randomized frames
        for (int k = 0; k < 20; k++) begin
            frame(N'($urandom_range(1, 15)), {$urandom, $urandom}, 8'($urandom),
                  $urandom_range(0, 5), $urandom_range(1, 8), 0, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
